// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: opcode encodings,
// opcode width and default latencies.
// The MADD/MADDU/MSUB/MSUBU encodings are always reserved here. They only
// decode to real operations when MDU_MADD_EN is defined.
package mdu_pkg;

    localparam int MDU_OP_W = 4;

    localparam logic [MDU_OP_W-1:0] OP_NONE  = 4'd0;
    localparam logic [MDU_OP_W-1:0] OP_MULT  = 4'd1;
    localparam logic [MDU_OP_W-1:0] OP_MULTU = 4'd2;
    localparam logic [MDU_OP_W-1:0] OP_DIV   = 4'd3;
    localparam logic [MDU_OP_W-1:0] OP_DIVU  = 4'd4;
    localparam logic [MDU_OP_W-1:0] OP_MFHI  = 4'd5;
    localparam logic [MDU_OP_W-1:0] OP_MFLO  = 4'd6;
    localparam logic [MDU_OP_W-1:0] OP_MTHI  = 4'd7;
    localparam logic [MDU_OP_W-1:0] OP_MTLO  = 4'd8;
    localparam logic [MDU_OP_W-1:0] OP_MADD  = 4'd9;
    localparam logic [MDU_OP_W-1:0] OP_MADDU = 4'd10;
    localparam logic [MDU_OP_W-1:0] OP_MSUB  = 4'd11;
    localparam logic [MDU_OP_W-1:0] OP_MSUBU = 4'd12;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Accumulate mode latched at start and applied at completion.
    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_ADD  = 2'd1;
    localparam logic [1:0] ACC_SUB  = 2'd2;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply/divide datapath.
// For multiplies the result is {hi, lo} = product.
// For divides the result is {hi, lo} = {remainder, quotient}.
// div_zero_o flags a zero divisor so that the controller can suppress the
// writeback. The value on res_* is meaningless in that case.
// When MDU_MADD_EN is defined, the accumulate opcodes reuse the product paths.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [MDU_OP_W-1:0] op_i,
    input  logic [31:0]         rs_i,
    input  logic [31:0]         rt_i,
    output logic [31:0]         res_hi_o,
    output logic [31:0]         res_lo_o,
    output logic                div_zero_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    // Both products are formed as 64x64 unsigned multiplies of the extended
    // operands. The low 64 bits are exact for the signed and unsigned cases.
    //
    // Signed divide works on magnitudes, so the 0x80000000 / -1 case yields a
    // quotient of 0x80000000 and a remainder of 0 without special handling.
    // A zero divisor is replaced by 1 to keep the dividers free of X.
    always_comb begin
        prod_s  = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
        prod_u  = {32'b0, rs_i} * {32'b0, rt_i};

        divisor = (rt_i == 32'd0) ? 32'd1 : rt_i;
        rs_mag  = rs_i[31] ? (32'd0 - rs_i) : rs_i;
        rt_mag  = divisor[31] ? (32'd0 - divisor) : divisor;
        q_mag   = rs_mag / rt_mag;
        r_mag   = rs_mag % rt_mag;
        q_s     = (rs_i[31] ^ divisor[31]) ? (32'd0 - q_mag) : q_mag;
        r_s     = rs_i[31] ? (32'd0 - r_mag) : r_mag;
        q_u     = rs_i / divisor;
        r_u     = rs_i % divisor;

        div_zero_o = ((op_i == OP_DIV) || (op_i == OP_DIVU)) && (rt_i == 32'd0);

        res_hi_o = 32'd0;
        res_lo_o = 32'd0;
        case (op_i)
            OP_MULT:  {res_hi_o, res_lo_o} = prod_s;
            OP_MULTU: {res_hi_o, res_lo_o} = prod_u;
            OP_DIV:   begin res_hi_o = r_s; res_lo_o = q_s; end
            OP_DIVU:  begin res_hi_o = r_u; res_lo_o = q_u; end
`ifdef MDU_MADD_EN
            OP_MADD,  OP_MSUB:  {res_hi_o, res_lo_o} = prod_s;
            OP_MADDU, OP_MSUBU: {res_hi_o, res_lo_o} = prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer. It owns HI/LO and models a fixed
// multi-cycle latency with a down-counter.
// A start edge captures the arith result into temp_q and loads the counter.
// The edge where the counter equals 1 commits temp_q to HI/LO and drops busy,
// so busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles. Legal values
// for both latencies are 1..15.
// A zero divisor still runs the full divide latency, but nothing is written.
// MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU. These accumulate into the HI/LO
// values present at completion. When the macro is undefined those encodings
// are treated as NONE and no accumulate adder exists.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         rs_data,
    input  logic [31:0]         rt_data,
    output logic                start,
    output logic                busy,
    output logic [31:0]         hi,
    output logic [31:0]         lo,
    output logic [31:0]         rd_data
);

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;

    logic        is_mul;
    logic        is_div;
    logic [3:0]  lat_d;
    logic [1:0]  acc_d;
    logic [63:0] hilo_d;

    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] temp_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        wb_q;
`ifdef MDU_MADD_EN
    logic [1:0]  acc_q;
`endif

    mdu_arith u_arith (
        .op_i       (op),
        .rs_i       (rs_data),
        .rt_i       (rt_data),
        .res_hi_o   (res_hi),
        .res_lo_o   (res_lo),
        .div_zero_o (div_zero)
    );

    // Decode the opcode into its operation class, latency and accumulate mode.
    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
        is_div = (op == OP_DIV)  || (op == OP_DIVU);
        acc_d  = ACC_NONE;
`ifdef MDU_MADD_EN
        if ((op == OP_MADD) || (op == OP_MADDU)) begin
            is_mul = 1'b1;
            acc_d  = ACC_ADD;
        end
        if ((op == OP_MSUB) || (op == OP_MSUBU)) begin
            is_mul = 1'b1;
            acc_d  = ACC_SUB;
        end
`endif
        lat_d = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end

    // Compute the completion value: a plain result, or an accumulate into HI/LO.
    always_comb begin
        hilo_d = temp_q;
`ifdef MDU_MADD_EN
        if (acc_q == ACC_ADD) hilo_d = {hi_q, lo_q} + temp_q;
        if (acc_q == ACC_SUB) hilo_d = {hi_q, lo_q} - temp_q;
`endif
    end

    assign start   = en && (is_mul || is_div) && !busy_q;
    assign busy    = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = (op == OP_MFHI) ? hi_q :
                     (op == OP_MFLO) ? lo_q : 32'd0;

    // Handle start, the countdown with commit, and MTHI/MTLO when idle.
    // Any op presented while busy is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            temp_q <= 64'd0;
            cnt_q  <= 4'd0;
            busy_q <= 1'b0;
            wb_q   <= 1'b0;
`ifdef MDU_MADD_EN
            acc_q  <= ACC_NONE;
`endif
        end else if (start) begin
            temp_q <= {res_hi, res_lo};
            cnt_q  <= lat_d;
            busy_q <= 1'b1;
            wb_q   <= !div_zero;
`ifdef MDU_MADD_EN
            acc_q  <= acc_d;
`endif
        end else if (busy_q) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_q <= 1'b0;
                if (wb_q) {hi_q, lo_q} <= hilo_d;
            end
        end else if (en && (op == OP_MTHI)) begin
            hi_q <= rs_data;
        end else if (en && (op == OP_MTLO)) begin
            lo_q <= rs_data;
        end
    end

`ifndef MDU_MADD_EN
    logic unused_acc;
    assign unused_acc = ^acc_d;
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with hand-computed expectations.
// Covers MDU_MADD_EN when the macro is defined. Otherwise it checks that the
// accumulate encodings are ignored.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .start   (start),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op for a single edge and check start just before that edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_start, input string tag);
        @(negedge clk);
        en = 1'b1; op = o; rs_data = a; rt_data = b;
        #1 check(tag, {31'b0, start}, {31'b0, exp_start});
        @(posedge clk);
        #1 en = 1'b0; op = OP_NONE;
    endtask

    // Count falling edges that see busy high. The count is capped at 40.
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; op = OP_NONE; rs_data = '0; rt_data = '0;
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_start", {31'b0, start}, 32'd0);
        @(negedge clk); reset = 1'b0;

        // MULT -2 * 3
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, "mult_start");
        check("mult_hi_held", hi, 32'd0);
        wait_idle(ncyc);
        check("mult_cycles", ncyc, 32'd5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);

        // MULTU 0xFFFFFFFF * 2
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1, "multu_start");
        wait_idle(ncyc);
        check("multu_cycles", ncyc, 32'd5);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);

        // DIV -7 / 2
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, "div_start");
        wait_idle(ncyc);
        check("div_cycles", ncyc, 32'd10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        // DIVU 7 / 0: runs the full latency, HI/LO untouched
        issue(OP_DIVU, 32'd7, 32'd0, 1'b1, "divu0_start");
        wait_idle(ncyc);
        check("divu0_cycles", ncyc, 32'd10);
        check("divu0_lo", lo, 32'hFFFFFFFD);
        check("divu0_hi", hi, 32'hFFFFFFFF);

        // DIV overflow case
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, "divov_start");
        wait_idle(ncyc);
        check("divov_lo", lo, 32'h80000000);
        check("divov_hi", hi, 32'd0);

        // MTHI / MTLO followed by MFHI / MFLO
        issue(OP_MTHI, 32'h00001234, 32'd0, 1'b0, "mthi_start");
        check("mthi_busy", {31'b0, busy}, 32'd0);
        @(negedge clk); op = OP_MFHI;
        #1 check("mfhi_rd", rd_data, 32'h00001234);
        op = OP_NONE;
        #1 check("none_rd", rd_data, 32'd0);
        issue(OP_MTLO, 32'h00000055, 32'd0, 1'b0, "mtlo_start");
        @(negedge clk); op = OP_MFLO;
        #1 check("mflo_rd", rd_data, 32'h00000055);
        op = OP_NONE;

        // MTLO and DIV presented while a MULT is in flight are dropped
        issue(OP_MULT, 32'd3, 32'd4, 1'b1, "mult2_start");
        issue(OP_MTLO, 32'h0000DEAD, 32'd0, 1'b0, "busy_mtlo_start");
        check("busy_mtlo_lo", lo, 32'h00000055);
        issue(OP_DIV, 32'd9, 32'd3, 1'b0, "busy_div_start");
        wait_idle(ncyc);
        check("mult2_rest_cycles", ncyc, 32'd3);
        check("mult2_hi", hi, 32'd0);
        check("mult2_lo", lo, 32'h0000000C);

        // en=0 with op=MULT does nothing
        @(negedge clk); en = 1'b0; op = OP_MULT; rs_data = 32'd5; rt_data = 32'd5;
        #1 check("en0_start", {31'b0, start}, 32'd0);
        @(posedge clk);
        #1 check("en0_busy", {31'b0, busy}, 32'd0);
        check("en0_lo", lo, 32'h0000000C);
        op = OP_NONE;

`ifdef MDU_MADD_EN
        // {0,0xC} + 2*3 = {0,0x12}; then {0,0x12} - 0x20 = -0xE
        issue(OP_MADD, 32'd2, 32'd3, 1'b1, "madd_start");
        wait_idle(ncyc);
        check("madd_cycles", ncyc, 32'd5);
        check("madd_lo", lo, 32'h00000012);
        check("madd_hi", hi, 32'd0);
        issue(OP_MSUB, 32'd1, 32'h20, 1'b1, "msub_start");
        wait_idle(ncyc);
        check("msub_lo", lo, 32'hFFFFFFF2);
        check("msub_hi", hi, 32'hFFFFFFFF);
`else
        issue(OP_MADD, 32'd2, 32'd3, 1'b0, "madd_off_start");
        check("madd_off_busy", {31'b0, busy}, 32'd0);
        check("madd_off_lo", lo, 32'h0000000C);
`endif

        // Reset asserted during cycle 3 of a DIV
        issue(OP_DIV, 32'd100, 32'd7, 1'b1, "rdiv_start");
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("rdiv_busy", {31'b0, busy}, 32'd0);
        check("rdiv_hi", hi, 32'd0);
        check("rdiv_lo", lo, 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (12) @(negedge clk);
        check("rdiv_late_busy", {31'b0, busy}, 32'd0);
        check("rdiv_late_hi", hi, 32'd0);
        check("rdiv_late_lo", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
